// File: rtl/fc2_bp_sequencer.sv
// Backward-pass beat sequencer for the FC2 layer: a weight-gradient pass, an idle gap,
// then a neuron-gradient pass, each walking neuron groups (outer) by activations (inner).
module fc2_bp_sequencer #(
    parameter int PREC       = 16,
    parameter int N_KERNELS  = 2,
    parameter int N_NEURONS  = 10,
    parameter int FAN_IN     = 64,
    parameter int GAP_CYCLES = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        forward,
    input  logic [N_NEURONS*PREC-1:0]   grad_i,
    output logic [5:0]                  act_rd_addr,
    input  logic [PREC-1:0]             act_rd_data,
    output logic [N_KERNELS*PREC-1:0]   b_gradient_o,
    output logic [N_KERNELS*PREC-1:0]   b_activation_o,
    output logic [5:0]                  b_activation_id_o,
    output logic [N_KERNELS*4-1:0]      b_neuron_id_o,
    output logic                        b_valid_o,
    output logic                        bp_mode_o,
    output logic                        busy,
    output logic                        done
);

    localparam int unsigned N_GROUPS = N_NEURONS / N_KERNELS;
    localparam int unsigned GW       = $clog2(N_GROUPS + 1);
    localparam int unsigned CW       = $clog2(GAP_CYCLES + 1);
    localparam int unsigned NW       = $clog2(N_NEURONS);

    typedef enum logic [1:0] {IDLE = 2'd0, WPASS = 2'd1, GAP = 2'd2, NPASS = 2'd3} state_t;

    state_t                     state, state_nx;
    logic [GW-1:0]              grp_q, grp_d;
    logic [5:0]                 act_q, act_d;
    logic [CW-1:0]              gap_q, gap_d;
    logic [PREC-1:0]            grad_q [N_NEURONS];
    logic                       accept, issue, pass_last;
    logic [N_KERNELS*PREC-1:0]  grad_d;
    logic [5:0]                 id_d;
    logic [N_KERNELS*4-1:0]     nid_d;
    logic                       valid_d, mode_d, done_d;

    assign accept    = (state == IDLE) && start && !forward;
    assign pass_last = (act_q == 6'(FAN_IN - 1)) && (grp_q == GW'(N_GROUPS - 1));
    // grp_q == N_GROUPS in NPASS marks the drain cycle after the last address
    assign issue     = (state == WPASS) || ((state == NPASS) && (grp_q != GW'(N_GROUPS)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = WPASS;
            WPASS:   if (pass_last) state_nx = GAP;
            GAP:     if (gap_q == CW'(GAP_CYCLES - 1)) state_nx = NPASS;
            NPASS:   if (!issue) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (forward) state_nx = IDLE;
    end

    always_comb begin
        grp_d   = grp_q;
        act_d   = act_q;
        gap_d   = gap_q;
        grad_d  = '0;
        id_d    = '0;
        nid_d   = '0;
        valid_d = 1'b0;
        mode_d  = 1'b0;
        done_d  = 1'b0;
        if (accept) begin
            grp_d = '0;
            act_d = '0;
            gap_d = '0;
        end
        if (issue) begin
            valid_d = 1'b1;
            mode_d  = (state == NPASS);
            id_d    = act_q;
            for (int i = 0; i < N_KERNELS; i++) begin
                grad_d[i*PREC +: PREC] = grad_q[NW'(int'(grp_q) * N_KERNELS + i)];
                nid_d[i*4 +: 4]        = 4'(int'(grp_q) * N_KERNELS + i);
            end
            if (act_q == 6'(FAN_IN - 1)) begin
                act_d = '0;
                grp_d = grp_q + GW'(1);
            end else begin
                act_d = act_q + 6'd1;
            end
            if ((state == WPASS) && pass_last) grp_d = '0;
        end
        if (state == GAP) gap_d = (gap_q == CW'(GAP_CYCLES - 1)) ? '0 : gap_q + CW'(1);
        if ((state == NPASS) && !issue) begin
            done_d = 1'b1;
            grp_d  = '0;
        end
        // Abort drops the in-flight beat and rewinds everything
        if (forward) begin
            grp_d   = '0;
            act_d   = '0;
            gap_d   = '0;
            grad_d  = '0;
            id_d    = '0;
            nid_d   = '0;
            valid_d = 1'b0;
            mode_d  = 1'b0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grp_q             <= '0;
            act_q             <= '0;
            gap_q             <= '0;
            for (int n = 0; n < N_NEURONS; n++) grad_q[n] <= '0;
            b_gradient_o      <= '0;
            b_activation_id_o <= '0;
            b_neuron_id_o     <= '0;
            b_valid_o         <= 1'b0;
            bp_mode_o         <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
        end else begin
            grp_q             <= grp_d;
            act_q             <= act_d;
            gap_q             <= gap_d;
            if (accept)
                for (int n = 0; n < N_NEURONS; n++) grad_q[n] <= grad_i[n*PREC +: PREC];
            b_gradient_o      <= grad_d;
            b_activation_id_o <= id_d;
            b_neuron_id_o     <= nid_d;
            b_valid_o         <= valid_d;
            bp_mode_o         <= mode_d;
            busy              <= (state_nx != IDLE);
            done              <= done_d;
        end
    end

    // The address counter is itself a register and rests at 0 outside the passes
    assign act_rd_addr = act_q;

    // Activation data arrives one cycle after its address, aligned with the registered beat
    assign b_activation_o = (b_valid_o && !bp_mode_o) ? {N_KERNELS{act_rd_data}} : '0;

endmodule

// File: tb/tb_fc2_bp_sequencer.sv
// Scoreboard bench for fc2_bp_sequencer: stimulus pushes the expected beat stream,
// a negedge monitor compares beats, busy, done and bp_mode every cycle.
module tb_fc2_bp_sequencer;
    localparam int PREC = 16;
    localparam int NK   = 2;
    localparam int NN   = 10;

    logic                 clk = 1'b0;
    logic                 rst, start, forward;
    logic [NN*PREC-1:0]   grad_i;
    logic [5:0]           act_rd_addr;
    logic [PREC-1:0]      act_rd_data;
    logic [NK*PREC-1:0]   b_gradient_o, b_activation_o;
    logic [5:0]           b_activation_id_o;
    logic [NK*4-1:0]      b_neuron_id_o;
    logic                 b_valid_o, bp_mode_o, busy, done;

    fc2_bp_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .forward(forward), .grad_i(grad_i),
        .act_rd_addr(act_rd_addr), .act_rd_data(act_rd_data),
        .b_gradient_o(b_gradient_o), .b_activation_o(b_activation_o),
        .b_activation_id_o(b_activation_id_o), .b_neuron_id_o(b_neuron_id_o),
        .b_valid_o(b_valid_o), .bp_mode_o(bp_mode_o), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [PREC-1:0] mem [64];
    always @(posedge clk) act_rd_data <= mem[act_rd_addr];

    typedef struct {
        int                 cyc;
        logic [NK*PREC-1:0] grad;
        logic [NK*PREC-1:0] act;
        logic [5:0]         id;
        logic [NK*4-1:0]    nid;
        logic               mode;
    } beat_t;

    beat_t q[$];
    int    busy_s = -1, busy_e = -2, done_cyc = -1;
    int    checks = 0, errors = 0;
    logic  mon_en = 1'b0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, exp);
        end
    endtask

    // Expected stream for an accepted start at cycle t: two passes of 5 groups x 64 activations
    function automatic void model_start(input int t, input logic [NN*PREC-1:0] g);
        beat_t b;
        busy_s   = t + 1;
        busy_e   = t + 649;
        done_cyc = t + 650;
        for (int p = 0; p < 2; p++)
            for (int grp = 0; grp < 5; grp++)
                for (int a = 0; a < 64; a++) begin
                    b.cyc  = (p == 0) ? t + 2 + grp*64 + a : t + 330 + grp*64 + a;
                    for (int i = 0; i < NK; i++) begin
                        b.grad[i*PREC +: PREC] = g[(2*grp + i)*PREC +: PREC];
                        b.act[i*PREC +: PREC]  = (p == 0) ? mem[a] : '0;
                        b.nid[i*4 +: 4]        = 4'(2*grp + i);
                    end
                    b.id   = 6'(a);
                    b.mode = (p == 1);
                    q.push_back(b);
                end
    endfunction

    function automatic void model_try(input int t, input logic [NN*PREC-1:0] g, input logic fwd);
        if (!fwd && !(t >= busy_s && t <= busy_e)) model_start(t, g);
    endfunction

    // Everything from cycle c onward is cancelled
    function automatic void model_cut(input int c);
        beat_t keep[$];
        foreach (q[k]) if (q[k].cyc < c) keep.push_back(q[k]);
        q = keep;
        if (busy_e >= c) busy_e = c - 1;
        if (done_cyc >= c) done_cyc = -1;
    endfunction

    always @(negedge clk) begin : monitor
        beat_t e;
        logic  exp_v;
        if (mon_en) begin
            chk("busy", 128'(busy), 128'(cyc >= busy_s && cyc <= busy_e));
            chk("done", 128'(done), 128'(cyc == done_cyc));
            exp_v = (q.size() > 0) && (q[0].cyc == cyc);
            chk("valid", 128'(b_valid_o), 128'(exp_v));
            if (exp_v) begin
                e = q.pop_front();
                chk("beat", {b_gradient_o, b_activation_o, b_activation_id_o, b_neuron_id_o, bp_mode_o},
                            {e.grad, e.act, e.id, e.nid, e.mode});
            end else begin
                chk("mode_idle", 128'(bp_mode_o), 128'(0));
            end
            if (!(cyc >= busy_s && cyc <= busy_e)) chk("addr_idle", 128'(act_rd_addr), 128'(0));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic goto(input int c);
        while (cyc < c) tick();
    endtask

    function automatic logic [NN*PREC-1:0] rnd_grad();
        logic [NN*PREC-1:0] r;
        for (int n = 0; n < NN; n++) r[n*PREC +: PREC] = PREC'($urandom);
        return r;
    endfunction

    task automatic rnd_mem();
        for (int a = 0; a < 64; a++) mem[a] = PREC'($urandom);
    endtask

    task automatic do_start(input logic [NN*PREC-1:0] g);
        grad_i = g;
        start  = 1'b1;
        model_try(cyc, g, forward);
        tick();
        start  = 1'b0;
        grad_i = rnd_grad();
    endtask

    task automatic do_abort();
        forward = 1'b1;
        model_cut(cyc + 1);
        tick();
        forward = 1'b0;
    endtask

    logic [NN*PREC-1:0] g0;
    int t0;

    initial begin
        rst = 1'b1; start = 1'b0; forward = 1'b0; grad_i = '0;
        for (int a = 0; a < 64; a++) mem[a] = PREC'(16'h0100 + a);
        repeat (3) tick();
        chk("reset_outputs", {b_gradient_o, b_activation_o, b_activation_id_o, b_neuron_id_o,
                              b_valid_o, bp_mode_o, busy, done, act_rd_addr}, '0);
        rst = 1'b0;
        tick();
        mon_en = 1'b1;
        tick();

        // Nominal: grad n+1, activations 0x0100+a
        for (int n = 0; n < NN; n++) g0[n*PREC +: PREC] = PREC'(n + 1);
        t0 = cyc;
        do_start(g0);
        goto(t0 + 660);

        // Start while busy is ignored
        rnd_mem();
        t0 = cyc;
        do_start(rnd_grad());
        goto(t0 + 100);
        do_start(rnd_grad());
        goto(t0 + 660);

        // Abort by forward mid weight pass
        rnd_mem();
        t0 = cyc;
        do_start(rnd_grad());
        goto(t0 + 200);
        do_abort();
        goto(t0 + 220);

        // Reset mid pass, then restart in the release cycle
        rnd_mem();
        t0 = cyc;
        do_start(rnd_grad());
        goto(t0 + 400);
        rst = 1'b1;
        model_cut(cyc);
        #1;
        chk("rst_async", {b_gradient_o, b_activation_o, b_valid_o, bp_mode_o, busy, done, act_rd_addr}, '0);
        tick();
        tick();
        rst = 1'b0;
        t0 = cyc;
        do_start(rnd_grad());
        goto(t0 + 660);

        // Simultaneous start and forward in IDLE
        forward = 1'b1;
        do_start(rnd_grad());
        forward = 1'b0;
        repeat (10) tick();

        // Random abort points across all phases
        for (int r = 0; r < 3; r++) begin
            rnd_mem();
            t0 = cyc;
            do_start(rnd_grad());
            goto(t0 + $urandom_range(1, 648));
            do_abort();
            goto(t0 + 660);
        end

        chk("queue_empty", 128'(q.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
        $fatal(1);
    end
endmodule
